input_queue: RTL and testbench
==============================

Name: input_queue

Overview:
- Per-port input buffer of the NoC router; one instance per direction (N, S, E, W, L).
- Accepts single-flit packets from the upstream link or the local core and stores them in a circular FIFO.
- Presents the head flit, its valid flag and its XY-routed output-port code to the crossbar and arbiter.
- Retires the head flit when the crossbar's pop request for this queue is asserted. It is the responder to the crossbar's pop_req/valid/data interface.

Parameters:
- DATA_W, 32, flit width in bits.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- X_COORD, 0, this router's X coordinate (4-bit value).
- Y_COORD, 0, this router's Y coordinate (4-bit value).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- push_i  in  1  upstream write strobe.
- data_i  in  DATA_W  upstream flit.
- full_o  out  1  queue full; upstream must not push.
- pop_req_i  in  1  pop request from the crossbar for this queue.
- q_o  out  DATA_W  head flit to the crossbar data muxes.
- valid_o  out  1  head flit present.
- route_o  out  3  requested output port of the head flit.
- drop_o  out  1  one-cycle pulse: a push was rejected.

Behaviour:
- Clock and reset:
  - One clock: clk. Reset rst is synchronous and active-high.
  - Reset clears read pointer, write pointer and count to 0.
  - Reset values: full_o=0, valid_o=0, route_o=3'b000, drop_o=0, q_o=0. Storage array is not reset.
  - rst wins over push/pop in the same cycle. In-flight contents are discarded; no pop or push is honoured in the reset cycle.
- Storage and status:
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits, range 0..DEPTH.
  - full_o = (count==DEPTH). valid_o = (count!=0). Both are decoded from registered count.
- Push:
  - Accepted when push_i && !full_o: mem[wr_ptr]<=data_i, wr_ptr++.
  - Rejected when push_i && full_o: drop_o=1 on the next cycle for one cycle; state unchanged.
  - A simultaneous pop does not make room in the same cycle.
- Pop:
  - Accepted when pop_req_i && valid_o: rd_ptr++.
  - pop_req_i while empty is ignored.
- Count update:
  - count +1 on push-only, -1 on pop-only, unchanged on push+pop (non-full, non-empty), unchanged when neither.
- Latency:
  - No fall-through. A flit pushed in cycle t is visible on q_o/valid_o in cycle t+1.
  - After a pop in cycle t, the next flit is on q_o in cycle t+1.
- Head outputs:
  - q_o = mem[rd_ptr] when valid_o, else 0. Combinational read of the registered pointer.
- Flit format: dest_x = flit[DATA_W-1:DATA_W-4], dest_y = flit[DATA_W-5:DATA_W-8].
- route_o (combinational from the head flit; 3'b000 when !valid_o), XY order:
  - dest_x>X_COORD -> 3'b011 (E)
  - dest_x<X_COORD -> 3'b100 (W)
  - else dest_y>Y_COORD -> 3'b001 (N)
  - dest_y<Y_COORD -> 3'b010 (S)
  - else 3'b101 (L)
- Arbiter contract: pop_req_i is asserted only for a head flit whose route was granted. The block does not re-check the grant.

Decomposition:
- Shared package noc_pkg:
  - Route codes: ROUTE_NONE=3'b000, ROUTE_N=3'b001, ROUTE_S=3'b010, ROUTE_E=3'b011, ROUTE_W=3'b100, ROUTE_L=3'b101.
  - Coordinate width constant COORD_W=4.
  - Flit header field offsets.
  - Typedef route_t (logic [2:0]).
  - The crossbar pop-request generators use the same route codes.
- One sub-module: xy_route_calc (combinational head-flit destination -> route_t, with X_COORD/Y_COORD parameters).
- FIFO control stays in input_queue.

Test Plan:
- Reset: assert rst with push_i=1 for 2 cycles -> valid_o=0, full_o=0, route_o=000, q_o=0, drop_o=0; no flit stored.
- Fill and overflow, DEPTH=4, X/Y=(1,1):
  - Push 0x2100_0000..0x2100_0003 on consecutive cycles -> full_o=1 after the 4th.
  - 5th push 0x5 -> drop_o pulses once, count stays 4.
  - route_o=011 (E).
- Drain in order: pop_req_i held 4 cycles -> q_o 0x2100_0000, _0001, _0002, _0003 in successive cycles; then valid_o=0, route_o=000. An extra pop while empty leaves pointers unchanged.
- Routing at (1,1) with head flits:
  - 0x0100_0000 -> 100 (W)
  - 0x1200_0000 -> 001 (N)
  - 0x1000_0000 -> 010 (S)
  - 0x1100_0000 -> 101 (L)
- Simultaneous push+pop:
  - Count=2: push+pop each cycle for 8 cycles -> count stays 2, FIFO order preserved across pointer wrap.
  - Count=0: push+pop in the same cycle -> push accepted, pop ignored, valid_o=1 next cycle.
- Full with simultaneous push+pop: count=4, push 0xA and pop together -> pop accepted, push dropped (drop_o=1), count=3, full_o=0 next cycle.

Source files
------------

// File: rtl/noc_pkg.sv
// noc_pkg: definitions shared by the NoC router blocks.
//   - route_t and the output-port route codes. The input queues and the
//     crossbar pop-request generators both use these codes.
//   - COORD_W: width of one router coordinate.
//   - Flit header field positions, measured from the flit MSB so that they
//     hold for any flit width.
package noc_pkg;

  typedef logic [2:0] route_t;

  localparam route_t ROUTE_NONE = 3'b000;
  localparam route_t ROUTE_N    = 3'b001;
  localparam route_t ROUTE_S    = 3'b010;
  localparam route_t ROUTE_E    = 3'b011;
  localparam route_t ROUTE_W    = 3'b100;
  localparam route_t ROUTE_L    = 3'b101;

  localparam int COORD_W = 4;

  // dest_x = flit[DATA_W-DEST_X_TOP_OFS -: COORD_W]
  // dest_y = flit[DATA_W-DEST_Y_TOP_OFS -: COORD_W]
  localparam int DEST_X_TOP_OFS = 1;
  localparam int DEST_Y_TOP_OFS = 1 + COORD_W;

endpackage

// File: rtl/input_queue_if.sv
// input_queue_if: groups the two links of one router input queue.
//   Upstream side : push_i, data_i (into the queue); full_o, drop_o (out).
//   Crossbar side : pop_req_i (into the queue); q_o, valid_o, route_o (out).
// Modports:
//   slave  - the queue itself.
//   master - the upstream sender and the crossbar/arbiter driving the queue.
interface input_queue_if
  import noc_pkg::*;
#(
  parameter int DATA_W = 32
);
  logic              push_i;
  logic [DATA_W-1:0] data_i;
  logic              full_o;
  logic              drop_o;
  logic              pop_req_i;
  logic [DATA_W-1:0] q_o;
  logic              valid_o;
  route_t            route_o;

  modport slave (
    input  push_i, data_i, pop_req_i,
    output full_o, drop_o, q_o, valid_o, route_o
  );

  modport master (
    output push_i, data_i, pop_req_i,
    input  full_o, drop_o, q_o, valid_o, route_o
  );
endinterface

// File: rtl/xy_route_calc.sv
// xy_route_calc: dimension-ordered (X first, then Y) routing decision for
// one flit destination, relative to this router's coordinates.
// Ports:
//   dest_x_i  in  COORD_W  destination X of the flit
//   dest_y_i  in  COORD_W  destination Y of the flit
//   route_o   out route_t  requested output port (E/W/N/S/L)
// Purely combinational.
module xy_route_calc
  import noc_pkg::*;
#(
  parameter logic [COORD_W-1:0] X_COORD = '0,
  parameter logic [COORD_W-1:0] Y_COORD = '0
) (
  input  logic [COORD_W-1:0] dest_x_i,
  input  logic [COORD_W-1:0] dest_y_i,
  output route_t             route_o
);

  always_comb begin
    route_o = ROUTE_L;
    if (dest_x_i > X_COORD) begin
      route_o = ROUTE_E;
    end else if (dest_x_i < X_COORD) begin
      route_o = ROUTE_W;
    end else if (dest_y_i > Y_COORD) begin
      route_o = ROUTE_N;
    end else if (dest_y_i < Y_COORD) begin
      route_o = ROUTE_S;
    end
  end

endmodule

// File: rtl/input_queue.sv
// input_queue: per-direction input buffer of the NoC router.
// Single-flit packets are written into a circular FIFO of DEPTH entries.
// The head flit, its valid flag and its XY route are offered to the crossbar,
// which retires the head with pop_req_i.
// Ports:
//   clk  in   clock
//   rst  in   synchronous active-high reset
//   bus  slave modport of input_queue_if
//        push_i/data_i/full_o/drop_o  upstream link
//        pop_req_i/q_o/valid_o/route_o crossbar link
// There is no fall-through: a pushed flit shows up at the head one cycle
// later. full_o/valid_o come from the registered count, so a pop does not
// free a slot for a push in the same cycle.
module input_queue
  import noc_pkg::*;
#(
  parameter int                 DATA_W  = 32,
  parameter int                 DEPTH   = 4,
  parameter logic [COORD_W-1:0] X_COORD = '0,
  parameter logic [COORD_W-1:0] Y_COORD = '0
) (
  input logic          clk,
  input logic          rst,
  input_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             drop_q,   drop_d;

  logic              full;
  logic              valid;
  logic              push_ok;
  logic              pop_ok;
  logic [DATA_W-1:0] head;
  route_t            head_route;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign valid   = (count_q != '0);
  assign push_ok = bus.push_i && !full;
  assign pop_ok  = bus.pop_req_i && valid;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    drop_d   = bus.push_i && full;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  // Storage has no reset; entries are only read once count covers them.
  always_ff @(posedge clk) begin
    if (push_ok && !rst) begin
      mem_q[wr_ptr_q] <= bus.data_i;
    end
  end

  assign head = mem_q[rd_ptr_q];

  xy_route_calc #(
    .X_COORD (X_COORD),
    .Y_COORD (Y_COORD)
  ) u_route (
    .dest_x_i (head[DATA_W-DEST_X_TOP_OFS -: COORD_W]),
    .dest_y_i (head[DATA_W-DEST_Y_TOP_OFS -: COORD_W]),
    .route_o  (head_route)
  );

  // Head outputs are forced to zero while empty so stale storage never leaks.
  assign bus.q_o     = valid ? head : '0;
  assign bus.route_o = valid ? head_route : ROUTE_NONE;
  assign bus.valid_o = valid;
  assign bus.full_o  = full;
  assign bus.drop_o  = drop_q;

endmodule

// File: tb/tb_input_queue.sv
// Testbench for input_queue (DEPTH=4, router at (1,1)).
// A reference queue model produces the expected head/status after each
// clock edge; a monitor compares the DUT against it on the falling edge.
module tb_input_queue;
  import noc_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  typedef struct {
    logic          valid;
    logic [DW-1:0] q;
    logic [2:0]    route;
    logic          full;
    logic          drop;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  input_queue_if #(.DATA_W(DW)) bus ();

  input_queue #(
    .DATA_W  (DW),
    .DEPTH   (DEPTH),
    .X_COORD (4'd1),
    .Y_COORD (4'd1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mdl[$];
  logic          mdl_drop = 1'b0;
  exp_t          exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;

  // XY routing for a router at (1,1), straight from the flit header fields.
  function automatic logic [2:0] exp_route(logic [DW-1:0] f);
    int dx, dy;
    dx = int'(f[31:28]);
    dy = int'(f[27:24]);
    if (dx > 1) return 3'b011;
    if (dx < 1) return 3'b100;
    if (dy > 1) return 3'b001;
    if (dy < 1) return 3'b010;
    return 3'b101;
  endfunction

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, let the edge happen, advance the model.
  task automatic step(logic r, logic push, logic [DW-1:0] data, logic pop);
    exp_t e;
    logic m_full, m_valid;
    rst           = r;
    bus.push_i    = push;
    bus.data_i    = data;
    bus.pop_req_i = pop;
    @(posedge clk);
    if (r) begin
      mdl.delete();
      mdl_drop = 1'b0;
    end else begin
      m_full   = (mdl.size() == DEPTH);
      m_valid  = (mdl.size() != 0);
      mdl_drop = push && m_full;
      if (pop && m_valid) void'(mdl.pop_front());
      if (push && !m_full) mdl.push_back(data);
    end
    e.valid = (mdl.size() != 0);
    e.q     = e.valid ? mdl[0] : '0;
    e.route = e.valid ? exp_route(mdl[0]) : 3'b000;
    e.full  = (mdl.size() == DEPTH);
    e.drop  = mdl_drop;
    exp_q.push_back(e);
    $display("cyc rst=%0b push=%0b data=%h pop=%0b -> exp valid=%0b q=%h route=%03b full=%0b drop=%0b",
             r, push, data, pop, e.valid, e.q, e.route, e.full, e.drop);
    #1;
  endtask

  // Monitor: compares whatever the DUT presents against the oldest record.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("valid_o", DW'(bus.valid_o), DW'(e.valid));
        chk("q_o",     bus.q_o,          e.q);
        chk("route_o", DW'(bus.route_o), DW'(e.route));
        chk("full_o",  DW'(bus.full_o),  DW'(e.full));
        chk("drop_o",  DW'(bus.drop_o),  DW'(e.drop));
      end
    end
  end

  logic [DW-1:0] route_flits [4];

  initial begin
    logic [DW-1:0] d;
    bus.push_i    = 1'b0;
    bus.data_i    = '0;
    bus.pop_req_i = 1'b0;
    #1;

    // Reset with push held high: nothing may be stored.
    step(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
    step(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);

    // Fill, overflow, idle.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h2100_0000 + DW'(i), 1'b0);
    step(1'b0, 1'b1, 32'h0000_0005, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);

    // Drain in order, then one pop while empty.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0);

    // Routing of individual head flits.
    route_flits[0] = 32'h0100_0000;
    route_flits[1] = 32'h1200_0000;
    route_flits[2] = 32'h1000_0000;
    route_flits[3] = 32'h1100_0000;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, route_flits[i], 1'b0);
      step(1'b0, 1'b0, '0, 1'b1);
    end

    // Count=2 with push+pop each cycle across pointer wrap.
    step(1'b0, 1'b1, 32'h3300_00A0, 1'b0);
    step(1'b0, 1'b1, 32'h3300_00A1, 1'b0);
    for (int i = 2; i < 10; i++) step(1'b0, 1'b1, 32'h3300_00A0 + DW'(i), 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);

    // Empty: push+pop together, push wins.
    step(1'b0, 1'b1, 32'h0011_2233, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);

    // Full: push+pop together, pop wins and the push is dropped.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h2200_0010 + DW'(i), 1'b0);
    step(1'b0, 1'b1, 32'h0000_000A, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      d = $urandom();
      d[31:28] = 4'($urandom_range(0, 2));
      d[27:24] = 4'($urandom_range(0, 2));
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) != 0), d,
           ($urandom_range(0, 2) != 0));
    end

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", DW'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
